// File: rtl/decoder_scan_sequencer_if.sv
// Command and decoder-drive signals between a scan controller and its requester.
// The requester drives the master side; the sequencer drives the slave side.
interface decoder_scan_sequencer_if #(
    parameter int unsigned DWELL_W = 8
);
    logic               start;
    logic               stop;
    logic               mode;
    logic [7:0]         ch_mask;
    logic [DWELL_W-1:0] dwell;
    logic [2:0]         sel;
    logic               en;
    logic               busy;
    logic               pass_done;

    modport master (
        output start, stop, mode, ch_mask, dwell,
        input  sel, en, busy, pass_done
    );

    modport slave (
        input  start, stop, mode, ch_mask, dwell,
        output sel, en, busy, pass_done
    );
endinterface

// File: rtl/decoder_scan_sequencer.sv
// Channel-scan controller feeding a 3-to-8 decoder: visits enabled mask channels in
// ascending order, dwell+1 cycles each, separated by a single blanking cycle.
module decoder_scan_sequencer #(
    parameter int unsigned DWELL_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    decoder_scan_sequencer_if.slave    bus
);
    localparam int unsigned CH_N  = 8;
    localparam int unsigned SEL_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        BLANK = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [CH_N-1:0]    mask_q, mask_d;
    logic               mode_q, mode_d;
    logic               en_q, en_d;
    logic               busy_q, busy_d;
    logic               pass_q, pass_d;
    logic [SEL_W:0]     nxt_ch;

    // Index of the lowest set bit (0 when the mask is empty).
    function automatic logic [SEL_W-1:0] lowest_ch(input logic [CH_N-1:0] m);
        lowest_ch = '0;
        for (int i = int'(CH_N) - 1; i >= 0; i--) begin
            if (m[i]) lowest_ch = SEL_W'(i);
        end
    endfunction

    // {found, index} of the nearest set bit strictly above cur.
    function automatic logic [SEL_W:0] next_ch(input logic [CH_N-1:0] m,
                                                input logic [SEL_W-1:0] cur);
        next_ch = '0;
        for (int i = int'(CH_N) - 1; i >= 0; i--) begin
            if (m[i] && (i > int'(cur))) next_ch = {1'b1, SEL_W'(i)};
        end
    endfunction

    always_comb nxt_ch = next_ch(mask_q, sel_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            dwell_q <= '0;
            mask_q  <= '0;
            mode_q  <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
            mask_q  <= mask_d;
            mode_q  <= mode_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        dwell_d = dwell_q;
        mask_d  = mask_q;
        mode_d  = mode_q;
        pass_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.stop && (bus.ch_mask != '0)) begin
                    mask_d  = bus.ch_mask;
                    dwell_d = bus.dwell;
                    mode_d  = bus.mode;
                    sel_d   = lowest_ch(bus.ch_mask);
                    cnt_d   = '0;
                    state_d = DWELL;
                end
            end
            DWELL: begin
                if (bus.stop) begin
                    state_d = IDLE;
                end else if (cnt_q != dwell_q) begin
                    cnt_d = cnt_q + DWELL_W'(1);
                end else if (nxt_ch[SEL_W]) begin
                    sel_d   = nxt_ch[SEL_W-1:0];
                    cnt_d   = '0;
                    state_d = BLANK;
                end else begin
                    // End of pass: wrap for continuous mode, otherwise park on the last channel.
                    pass_d = 1'b1;
                    if (mode_q) begin
                        sel_d   = lowest_ch(mask_q);
                        cnt_d   = '0;
                        state_d = BLANK;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            BLANK: begin
                state_d = bus.stop ? IDLE : DWELL;
            end
            default: state_d = IDLE;
        endcase

        en_d   = (state_d == DWELL);
        busy_d = (state_d != IDLE);
    end

    assign bus.sel       = sel_q;
    assign bus.en        = en_q;
    assign bus.busy      = busy_q;
    assign bus.pass_done = pass_q;
endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Randomized and directed checks of decoder_scan_sequencer against a queue-based
// model that expands each accepted scan into its expected per-cycle output trace.
module tb_decoder_scan_sequencer;
    localparam int unsigned DWELL_W = 8;

    typedef struct packed {
        logic [2:0] sel;
        logic       en;
        logic       busy;
        logic       pd;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    decoder_scan_sequencer_if #(.DWELL_W(DWELL_W)) bus ();

    decoder_scan_sequencer #(.DWELL_W(DWELL_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    obs_t               exp_o;
    obs_t               q[$];
    logic [7:0]         mask_m;
    logic [DWELL_W-1:0] dwell_m;
    logic               cont_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic obs_t mk(input int s, input logic e, input logic b, input logic p);
        obs_t o;
        o.sel  = 3'(s);
        o.en   = e;
        o.busy = b;
        o.pd   = p;
        return o;
    endfunction

    // Append one full pass (dwell cycles plus the gap that follows each channel).
    task automatic add_pass();
        int chs[$];
        for (int i = 0; i < 8; i++) if (mask_m[i]) chs.push_back(i);
        for (int k = 0; k < chs.size(); k++) begin
            for (int d = 0; d <= int'(dwell_m); d++) q.push_back(mk(chs[k], 1'b1, 1'b1, 1'b0));
            if (k + 1 < chs.size())  q.push_back(mk(chs[k+1], 1'b0, 1'b1, 1'b0));
            else if (cont_m)         q.push_back(mk(chs[0], 1'b0, 1'b1, 1'b1));
            else                     q.push_back(mk(chs[k], 1'b0, 1'b0, 1'b1));
        end
    endtask

    task automatic model_step();
        obs_t nx;
        if (exp_o.busy) begin
            if (bus.stop) begin
                nx = mk(int'(exp_o.sel), 1'b0, 1'b0, 1'b0);
                q.delete();
            end else begin
                if (q.size() == 0 && cont_m) add_pass();
                nx = q.pop_front();
            end
        end else if (bus.start && !bus.stop && bus.ch_mask != 8'h00) begin
            mask_m  = bus.ch_mask;
            dwell_m = bus.dwell;
            cont_m  = bus.mode;
            q.delete();
            add_pass();
            nx = q.pop_front();
        end else begin
            nx = mk(int'(exp_o.sel), 1'b0, 1'b0, 1'b0);
        end
        exp_o = nx;
    endtask

    task automatic compare_outputs(input string tag);
        check({tag, ".sel"},  32'(bus.sel),       32'(exp_o.sel));
        check({tag, ".en"},   32'(bus.en),        32'(exp_o.en));
        check({tag, ".busy"}, 32'(bus.busy),      32'(exp_o.busy));
        check({tag, ".pd"},   32'(bus.pass_done), 32'(exp_o.pd));
    endtask

    // One clock: model and DUT see the same inputs; start/stop are single-cycle.
    task automatic cycle(input string tag);
        @(posedge clk);
        model_step();
        #1;
        compare_outputs(tag);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
    endtask

    task automatic cmd_start(input logic [7:0] m, input int d, input logic md);
        bus.ch_mask = m;
        bus.dwell   = DWELL_W'(d);
        bus.mode    = md;
        bus.start   = 1'b1;
    endtask

    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        exp_o = mk(0, 1'b0, 1'b0, 1'b0);
        q.delete();
        compare_outputs(tag);
        #2 rst = 1'b0;
    endtask

    int busy_cnt;
    int pd_cnt;

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.stop = 1'b0; bus.mode = 1'b0;
        bus.ch_mask = 8'h00; bus.dwell = '0;
        exp_o = mk(0, 1'b0, 1'b0, 1'b0);
        mask_m = '0; dwell_m = '0; cont_m = 1'b0;
        #12;
        compare_outputs("reset");
        rst = 1'b0;

        for (int i = 0; i < 20; i++) cycle("idle");

        // Single pass over 0,2,5,7 with dwell 2.
        cmd_start(8'b1010_0101, 2, 1'b0);
        busy_cnt = 0;
        pd_cnt   = 0;
        for (int i = 0; i < 20; i++) begin
            cycle("single");
            if (bus.busy) busy_cnt++;
            if (bus.pass_done) pd_cnt++;
        end
        check("single.busy_len", 32'(busy_cnt), 32'd15);
        check("single.pd_count", 32'(pd_cnt), 32'd1);
        check("single.sel_hold", 32'(bus.sel), 32'd7);

        // Continuous 0/7 with dwell 0, then a mid-pass ch_mask change and a stray start.
        cmd_start(8'b1000_0001, 0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            if (i == 5) bus.ch_mask = 8'h3C;
            if (i == 7) cmd_start(8'h02, 3, 1'b0);
            cycle("cont");
        end
        bus.stop = 1'b1;
        cycle("cont_stop");

        // Abort during the 2nd dwell cycle of channel 4.
        cmd_start(8'hFF, 3, 1'b1);
        for (int i = 0; i < 22; i++) cycle("abort_run");
        check("abort.pre_sel", 32'(bus.sel), 32'd4);
        bus.stop = 1'b1;
        cycle("abort");
        check("abort.sel", 32'(bus.sel), 32'd4);
        check("abort.busy", 32'(bus.busy), 32'd0);
        cmd_start(8'hFF, 3, 1'b1);
        cycle("restart");
        check("restart.sel", 32'(bus.sel), 32'd0);
        for (int i = 0; i < 6; i++) cycle("restart_run");
        bus.stop = 1'b1;
        cycle("restart_stop");

        // Empty mask, and start together with stop, in IDLE.
        cmd_start(8'h00, 1, 1'b1);
        for (int i = 0; i < 4; i++) cycle("zero_mask");
        cmd_start(8'h0F, 1, 1'b1);
        bus.stop = 1'b1;
        for (int i = 0; i < 4; i++) cycle("start_stop");

        // Largest dwell on a single channel.
        cmd_start(8'h10, 255, 1'b0);
        for (int i = 0; i < 262; i++) cycle("max_dwell");

        // Asynchronous reset between edges while en is high.
        cmd_start(8'h66, 2, 1'b1);
        cycle("pre_rst");
        cycle("pre_rst");
        check("pre_rst.en", 32'(bus.en), 32'd1);
        async_reset("mid_rst");
        for (int i = 0; i < 3; i++) cycle("post_rst");

        // Randomized commands, live input changes and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            bus.mode    = 1'($urandom_range(0, 1));
            bus.ch_mask = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
            bus.dwell   = DWELL_W'($urandom_range(0, 4));
            bus.start   = ($urandom_range(0, 7) == 0);
            bus.stop    = ($urandom_range(0, 39) == 0);
            cycle("rand");
            if ($urandom_range(0, 299) == 0) async_reset("rand_rst");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
